// File: rtl/ktc32_pkg.sv
// ktc32 shared constants: memwrite encodings, MMIO map, CTRL bits.
// Also holds the store lane helpers used by the memory system.
package ktc32_pkg;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_BYTE = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_WORD = 2'b11;

  localparam logic [3:0] OFF_LED    = 4'h0;
  localparam logic [3:0] OFF_TCOUNT = 4'h4;
  localparam logic [3:0] OFF_TCMP   = 4'h8;
  localparam logic [3:0] OFF_CTRL   = 4'hC;

  localparam int CTRL_TEN    = 0;
  localparam int CTRL_IRQEN  = 1;
  localparam int CTRL_PEND   = 2;
  localparam int CTRL_MISAL  = 3;
  localparam int CTRL_BUSERR = 4;

  function automatic logic [3:0] lane_en(
    input logic [1:0] mw,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'b0000;
    case (mw)
      MW_BYTE: be = 4'b0001 << a;
      MW_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      MW_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] mw,
    input logic [1:0] a
  );
    return ((mw == MW_HALF) && a[0]) ||
           ((mw == MW_WORD) && (a != 2'b00));
  endfunction

  // replicate right-aligned data so any lane sees its byte
  function automatic logic [31:0] place(
    input logic [1:0]  mw,
    input logic [31:0] wd
  );
    logic [31:0] r;
    r = wd;
    case (mw)
      MW_BYTE: r = {4{wd[7:0]}};
      MW_HALF: r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/ktc32_timer.sv
// ktc32 timer: free-running counter with compare and
// level interrupt, plus the ten/irq_en/irq_pend CTRL bits.
module ktc32_timer
  import ktc32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic        we_count,
  input  logic        we_cmp,
  input  logic        we_ctrl,
  output logic [31:0] tcount,
  output logic [31:0] tcmp,
  output logic        ten,
  output logic        irq_en,
  output logic        irq_pend,
  output logic        timer_irq
);

  logic [31:0] nxt;
  logic        hit;
  logic        ctl_w;

  assign nxt   = tcount + 32'd1;
  assign ctl_w = we_ctrl & be[0];
  // a core write to TCOUNT suppresses both increment and compare
  assign hit   = ten & ~we_count & (nxt == tcmp);

  assign timer_irq = irq_pend & irq_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcount   <= '0;
      tcmp     <= '0;
      ten      <= 1'b0;
      irq_en   <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      if (we_count)
        tcount <= merge(tcount, wdata, be);
      else if (ten)
        tcount <= nxt;
      if (we_cmp)
        tcmp <= merge(tcmp, wdata, be);
      if (ctl_w) begin
        ten    <= wdata[CTRL_TEN];
        irq_en <= wdata[CTRL_IRQEN];
      end
      irq_pend <= hit |
        (irq_pend & ~(ctl_w & wdata[CTRL_PEND]));
    end
  end

endmodule

// File: rtl/ktc32_memsys.sv
// ktc32 memory system: unified byte-writable RAM plus
// MMIO LED, timer and status registers on one core port.
module ktc32_memsys
  import ktc32_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [7:0]  led,
  output logic        timer_irq
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];

  logic [AW-1:0] idx;
  logic          ram_sel;
  logic          mmio_sel;
  logic [3:0]    reg_off;
  logic          wr;
  logic          mis;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wdat;
  logic          we_led;
  logic          we_count;
  logic          we_cmp;
  logic          we_ctrl;
  logic          ctl_w;
  logic          bus_ev;
  logic          misal_q;
  logic          buserr_q;
  logic [31:0]   tcount;
  logic [31:0]   tcmp;
  logic          ten;
  logic          irq_en;
  logic          irq_pend;
  logic [31:0]   ctrl_rd;

  assign idx      = addr[AW+1:2];
  assign ram_sel  = (addr[31:AW+2] == '0);
  assign mmio_sel = (addr[31:4] == MMIO_BASE[31:4]);
  assign reg_off  = {addr[3:2], 2'b00};

  assign wr   = (memwrite != MW_NONE);
  assign mis  = wr & misaligned(memwrite, addr[1:0]);
  assign we   = wr & ~mis;
  assign be   = we ? lane_en(memwrite, addr[1:0]) : 4'b0000;
  assign wdat = place(memwrite, wd);

  assign we_led   = we & mmio_sel & (reg_off == OFF_LED);
  assign we_count = we & mmio_sel & (reg_off == OFF_TCOUNT);
  assign we_cmp   = we & mmio_sel & (reg_off == OFF_TCMP);
  assign we_ctrl  = we & mmio_sel & (reg_off == OFF_CTRL);
  assign ctl_w    = we_ctrl & be[0];
  assign bus_ev   = wr & ~ram_sel & ~mmio_sel;

  // RAM is never reset; a store seen with reset high is dropped
  always_ff @(posedge clk) begin
    if (!reset && ram_sel) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led      <= '0;
      misal_q  <= 1'b0;
      buserr_q <= 1'b0;
    end else begin
      if (we_led && be[0])
        led <= wdat[7:0];
      misal_q <= mis |
        (misal_q & ~(ctl_w & wdat[CTRL_MISAL]));
      buserr_q <= bus_ev |
        (buserr_q & ~(ctl_w & wdat[CTRL_BUSERR]));
    end
  end

  ktc32_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .wdata     (wdat),
    .be        (be),
    .we_count  (we_count),
    .we_cmp    (we_cmp),
    .we_ctrl   (we_ctrl),
    .tcount    (tcount),
    .tcmp      (tcmp),
    .ten       (ten),
    .irq_en    (irq_en),
    .irq_pend  (irq_pend),
    .timer_irq (timer_irq)
  );

  assign ctrl_rd = {27'b0, buserr_q, misal_q,
                    irq_pend, irq_en, ten};

  always_comb begin
    rd = '0;
    if (ram_sel) begin
      rd = mem[idx];
    end else if (mmio_sel) begin
      case (reg_off)
        OFF_LED:    rd = {24'b0, led};
        OFF_TCOUNT: rd = tcount;
        OFF_TCMP:   rd = tcmp;
        OFF_CTRL:   rd = ctrl_rd;
        default:    rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ktc32_memsys.sv
// Directed bench for ktc32_memsys: table of store/readback
// vectors followed by timer, collision, unmapped and reset sequences.
module tb_ktc32_memsys;
  import ktc32_pkg::*;

  localparam logic [31:0] M  = 32'hFFFF_0000;
  localparam logic [31:0] LD = M + 32'h0;
  localparam logic [31:0] TC = M + 32'h4;
  localparam logic [31:0] TM = M + 32'h8;
  localparam logic [31:0] CT = M + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  memwrite = MW_NONE;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic [7:0]  led;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  ktc32_memsys #(
    .MEM_WORDS (256),
    .MMIO_BASE (M),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .wd        (wd),
    .rd        (rd),
    .led       (led),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mw;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] ca;
    logic [31:0] exp;
  } vec_t;

  vec_t tv[19];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic store(input logic [1:0] mw,
                       input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    memwrite = mw;
    addr = a;
    wd = d;
    @(posedge clk);
    #1;
    memwrite = MW_NONE;
  endtask

  task automatic check_rd(input string nm,
                          input logic [31:0] a,
                          input logic [31:0] exp);
    addr = a;
    #1;
    check(nm, rd, exp);
  endtask

  logic hit;
  logic irq_before;

  initial begin
    tv[0]  = '{MW_WORD, 32'h14, 32'h0BAD_F00D, 32'h14, 32'h0BAD_F00D};
    tv[1]  = '{MW_WORD, 32'h10, 32'hDEAD_BEEF, 32'h10, 32'hDEAD_BEEF};
    tv[2]  = '{MW_NONE, 32'h10, 32'h0,         32'h14, 32'h0BAD_F00D};
    tv[3]  = '{MW_WORD, 32'h10, 32'h1122_3344, 32'h10, 32'h1122_3344};
    tv[4]  = '{MW_BYTE, 32'h13, 32'h0000_00AA, 32'h10, 32'hAA22_3344};
    tv[5]  = '{MW_HALF, 32'h10, 32'h0000_5566, 32'h10, 32'hAA22_5566};
    tv[6]  = '{MW_BYTE, 32'h11, 32'hFFFF_FF77, 32'h10, 32'hAA22_7766};
    tv[7]  = '{MW_HALF, 32'h12, 32'hABCD_1234, 32'h10, 32'h1234_7766};
    tv[8]  = '{MW_WORD, 32'h20, 32'h1234_5678, 32'h20, 32'h1234_5678};
    tv[9]  = '{MW_HALF, 32'h21, 32'h0000_9999, 32'h20, 32'h1234_5678};
    tv[10] = '{MW_NONE, 32'h20, 32'h0,         CT,     32'h0000_0008};
    tv[11] = '{MW_WORD, CT,     32'h0000_0008, CT,     32'h0000_0000};
    tv[12] = '{MW_WORD, LD,     32'hFFFF_FFA5, LD,     32'h0000_00A5};
    tv[13] = '{MW_BYTE, LD + 1, 32'h0000_003C, LD,     32'h0000_00A5};
    tv[14] = '{MW_WORD, 32'h22, 32'h0000_1111, 32'h20, 32'h1234_5678};
    tv[15] = '{MW_NONE, 32'h20, 32'h0,         CT,     32'h0000_0008};
    tv[16] = '{MW_WORD, CT,     32'h0000_0008, CT,     32'h0000_0000};
    tv[17] = '{MW_WORD, TM,     32'hCAFE_F00D, TM,     32'hCAFE_F00D};
    tv[18] = '{MW_WORD, CT,     32'hFFFF_FFE0, CT,     32'h0000_0000};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_led", {24'b0, led}, 32'h0);
    check("rst_irq", {31'b0, timer_irq}, 32'h0);
    check_rd("rst_ctrl", CT, 32'h0);
    check_rd("rst_tcount", TC, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      store(tv[i].mw, tv[i].a, tv[i].d);
      check_rd($sformatf("vec%0d", i), tv[i].ca, tv[i].exp);
    end
    check("led_port", {24'b0, led}, 32'h0000_00A5);

    // timer compare
    store(MW_WORD, TM, 32'd5);
    store(MW_WORD, TC, 32'd0);
    store(MW_WORD, CT, 32'h3);
    addr = TC;
    hit = 1'b0;
    irq_before = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (rd == 32'd5) begin
        hit = 1'b1;
        break;
      end
      irq_before = timer_irq;
    end
    check("t4_reach5", {31'b0, hit}, 32'h1);
    check("t4_irq_at5", {31'b0, timer_irq}, 32'h1);
    check("t4_irq_at4", {31'b0, irq_before}, 32'h0);
    check_rd("t4_ctrl", CT, 32'h7);
    store(MW_WORD, CT, 32'h4);
    check("t4_irq_clr", {31'b0, timer_irq}, 32'h0);
    check_rd("t4_ctrl_clr", CT, 32'h0);

    // wrap and write/increment collision
    store(MW_WORD, TM, 32'h200);
    store(MW_WORD, CT, 32'h1);
    store(MW_WORD, TC, 32'hFFFF_FFFF);
    check_rd("t5_ffff", TC, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check("t5_wrap", rd, 32'h0);
    store(MW_WORD, TC, 32'h100);
    check_rd("t5_wr", TC, 32'h100);
    @(posedge clk);
    #1;
    check("t5_inc", rd, 32'h101);

    // pending set and its W1C on the same edge
    store(MW_WORD, TM, 32'h110);
    store(MW_WORD, TC, 32'h10F);
    store(MW_WORD, CT, 32'h5);
    check_rd("pend_set_wins", CT, 32'h5);
    check("pend_no_irq", {31'b0, timer_irq}, 32'h0);
    store(MW_WORD, CT, 32'h1C);
    check_rd("ctrl_all_clr", CT, 32'h0);

    // unmapped
    check_rd("unm_rd", 32'h8000_0000, 32'h0);
    check_rd("unm_rd_nobus", CT, 32'h0);
    store(MW_WORD, 32'h8000_0000, 32'h1234_5678);
    check_rd("unm_rd2", 32'h8000_0000, 32'h0);
    check_rd("buserr", CT, 32'h10);

    // live state, then reset mid-store
    store(MW_WORD, LD, 32'h5A);
    store(MW_WORD, TM, 32'd3);
    store(MW_WORD, TC, 32'd0);
    store(MW_WORD, CT, 32'h3);
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_irq", {31'b0, timer_irq}, 32'h1);
    check("pre_rst_led", {24'b0, led}, 32'h5A);
    @(negedge clk);
    reset = 1'b1;
    addr = 32'h14;
    wd = 32'hFFFF_FFFF;
    memwrite = MW_WORD;
    #1;
    check("rst_async_led", {24'b0, led}, 32'h0);
    check("rst_async_irq", {31'b0, timer_irq}, 32'h0);
    @(posedge clk);
    #1;
    memwrite = MW_NONE;
    check_rd("rst_drop", 32'h14, 32'h0BAD_F00D);
    check_rd("rst_ram", 32'h10, 32'h1234_7766);
    check_rd("rst_ctrl2", CT, 32'h0);
    check_rd("rst_tc2", TC, 32'h0);
    check_rd("rst_tm2", TM, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    store(MW_WORD, 32'h30, 32'hA5A5_0F0F);
    check_rd("post_rst_st", 32'h30, 32'hA5A5_0F0F);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
